ram_rd_check: RTL and testbench

- Read-side checker on the single-port RAM interface, the counterpart of the RAM read/write stimulus generator.
- Snoops the generator's control and write signals and keeps a shadow copy of every written word.
- Aligns each issued read with the RAM's returned data after the read latency and compares the two.
- Reports per-read results, error counts, first-failure capture and a pass/fail state for LED/debug use.

---
 rtl/ram_rd_check.sv | 149 ++++++++++++++
 tb/tb_ram_rd_check.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_check.sv
// rtl/ram_rd_check.sv - read-side checker for the single-port RAM stimulus generator
module ram_rd_check #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_en,
    input  logic              ram_wea,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    input  logic              clr,
    output logic              chk_valid,
    output logic              chk_ok,
    output logic              rd_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  round_cnt,
    output logic              round_pass,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAIL = 2'd2} state_t;

    localparam logic [ADDR_W:0]  RUN_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state_q, state_d;

    logic [DATA_W-1:0]     shadow [DEPTH];
    logic [DEPTH-1:0]      shadow_vld;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [ADDR_W-1:0]     pipe_addr [RD_LATENCY];
    logic [DATA_W-1:0]     pipe_exp  [RD_LATENCY];

    logic              wr, issue, cmp, match, hit, mism;
    logic [ADDR_W:0]   run_len, run_base;
    logic [CNT_W-1:0]  err_base, round_base;
    logic              first_vld, first_base;

    assign wr    = ram_en & ram_wea;
    assign issue = ram_en & ~ram_wea;

    // Shadow data needs no reset; the valid bits gate every compare.
    always_ff @(posedge clk) begin
        if (wr) shadow[ram_addr] <= ram_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_vld <= '0;
        else if (wr) shadow_vld[ram_addr] <= 1'b1;
    end

    // Reads to never-written addresses enter as empty slots: no compare later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue & shadow_vld[ram_addr];
            pipe_addr[0] <= ram_addr;
            pipe_exp[0]  <= shadow[ram_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end
        end
    end

    assign cmp   = pipe_vld[RD_LATENCY-1];
    assign match = (ram_rd_data == pipe_exp[RD_LATENCY-1]);
    assign hit   = cmp & match;
    assign mism  = cmp & ~match;

    // clr takes effect first, then the same-cycle compare lands on the cleared values.
    assign run_base   = clr ? '0 : run_len;
    assign err_base   = clr ? '0 : err_cnt;
    assign round_base = clr ? '0 : round_cnt;
    assign first_base = clr ? 1'b0 : first_vld;

    always_comb begin
        state_d = clr ? IDLE : state_q;
        if (mism) state_d = FAIL;
        else if (hit && state_d == IDLE) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    assign rd_err = (state_q == FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid      <= 1'b0;
            chk_ok         <= 1'b0;
            round_pass     <= 1'b0;
            err_cnt        <= '0;
            round_cnt      <= '0;
            run_len        <= '0;
            first_vld      <= 1'b0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else begin
            chk_valid  <= cmp;
            chk_ok     <= hit;
            round_pass <= 1'b0;
            if (clr) begin
                err_cnt        <= '0;
                round_cnt      <= '0;
                run_len        <= '0;
                first_vld      <= 1'b0;
                first_err_addr <= '0;
                first_err_exp  <= '0;
                first_err_act  <= '0;
            end
            if (mism) begin
                run_len <= '0;
                if (err_base != CNT_MAX) err_cnt <= err_base + CNT_W'(1);
                if (!first_base) begin
                    first_vld      <= 1'b1;
                    first_err_addr <= pipe_addr[RD_LATENCY-1];
                    first_err_exp  <= pipe_exp[RD_LATENCY-1];
                    first_err_act  <= ram_rd_data;
                end
            end else if (hit) begin
                if (run_base == RUN_LAST) begin
                    run_len    <= '0;
                    round_pass <= 1'b1;
                    if (round_base != CNT_MAX) round_cnt <= round_base + CNT_W'(1);
                end else begin
                    run_len <= run_base + (ADDR_W + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_check.sv
// tb/tb_ram_rd_check.sv - directed bench: latency 1 / 16-bit counters and latency 3 / 4-bit counters
module tb_ram_rd_check;

    logic       clk = 1'b0;
    logic       rst_n, ram_en, ram_wea, clr, corrupt;
    logic [4:0] ram_addr;
    logic [7:0] ram_wr_data, bad_val, rd1;
    logic [7:0] mem [32];
    logic [7:0] p3  [3];
    logic [7:0] rd3;

    logic        c1_valid, c1_ok, c1_err, c1_rp;
    logic [15:0] c1_err_cnt, c1_round_cnt;
    logic [4:0]  c1_fe_addr;
    logic [7:0]  c1_fe_exp, c1_fe_act;
    logic        c3_valid, c3_ok, c3_err, c3_rp;
    logic [3:0]  c3_err_cnt, c3_round_cnt;
    logic [4:0]  c3_fe_addr;
    logic [7:0]  c3_fe_exp, c3_fe_act;

    int n_vec = 0, n_err = 0;
    int n_chk1 = 0, n_bad1 = 0, n_rp1 = 0, rp_at1 = 0, bad_at1 = 0;
    int n_chk3 = 0, n_bad3 = 0;
    int b_chk1, b_bad1, b_rp1, b_chk3, b_bad3;

    always #5 clk = ~clk;

    ram_rd_check #(.RD_LATENCY(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_wea(ram_wea), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(rd1), .clr(clr),
        .chk_valid(c1_valid), .chk_ok(c1_ok), .rd_err(c1_err), .err_cnt(c1_err_cnt),
        .round_cnt(c1_round_cnt), .round_pass(c1_rp), .first_err_addr(c1_fe_addr),
        .first_err_exp(c1_fe_exp), .first_err_act(c1_fe_act)
    );

    ram_rd_check #(.RD_LATENCY(3), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .ram_en(ram_en), .ram_wea(ram_wea), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(rd3), .clr(clr),
        .chk_valid(c3_valid), .chk_ok(c3_ok), .rd_err(c3_err), .err_cnt(c3_err_cnt),
        .round_cnt(c3_round_cnt), .round_pass(c3_rp), .first_err_addr(c3_fe_addr),
        .first_err_exp(c3_fe_exp), .first_err_act(c3_fe_act)
    );

    // RAM model: one read path per latency, with optional data corruption.
    always @(posedge clk) begin
        if (ram_en && ram_wea) mem[ram_addr] <= ram_wr_data;
        if (ram_en && !ram_wea) begin
            rd1   <= corrupt ? bad_val : mem[ram_addr];
            p3[0] <= corrupt ? bad_val : mem[ram_addr];
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    always @(negedge clk) begin
        if (c1_valid) begin
            n_chk1++;
            if (!c1_ok) begin n_bad1++; bad_at1 = n_chk1; end
        end
        if (c1_rp) begin n_rp1++; rp_at1 = n_chk1; end
        if (c3_valid) begin
            n_chk3++;
            if (!c3_ok) n_bad3++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic we, input logic [4:0] a, input logic [7:0] d,
                       input logic cor, input logic [7:0] bv, input logic c);
        @(negedge clk);
        ram_en = en; ram_wea = we; ram_addr = a; ram_wr_data = d;
        corrupt = cor; bad_val = bv; clr = c;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(1'b1, 1'b0, a, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic rdbad(input logic [4:0] a, input logic [7:0] v);
        cyc(1'b1, 1'b0, a, 8'd0, 1'b1, v, 1'b0);
    endtask

    task automatic write_all;
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, 5'(k), 8'(k), 1'b0, 8'd0, 1'b0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; ram_en = 1'b0; clr = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic snap;
        b_chk1 = n_chk1; b_bad1 = n_bad1; b_rp1 = n_rp1; b_chk3 = n_chk3; b_bad3 = n_bad3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ram_en = 1'b0; ram_wea = 1'b0; ram_addr = '0; ram_wr_data = '0;
        clr = 1'b0; corrupt = 1'b0; bad_val = '0;
        idle(2);
        check("rst_chk_valid", 32'(c1_valid), 32'd0);
        check("rst_err_cnt", 32'(c1_err_cnt), 32'd0);
        check("rst_round_cnt", 32'(c1_round_cnt), 32'd0);
        check("rst_rd_err", 32'(c1_err), 32'd0);
        check("rst_first_err_addr", 32'(c1_fe_addr), 32'd0);
        check("rst_state", 32'(u1.state_q), 32'd0);
        rst_n = 1'b1;

        // Reads of never-written addresses produce no compares.
        snap();
        for (int a = 0; a < 32; a++) rd(5'(a));
        idle(5);
        check("unwritten_chk1", 32'(n_chk1 - b_chk1), 32'd0);
        check("unwritten_chk3", 32'(n_chk3 - b_chk3), 32'd0);
        check("unwritten_err_cnt", 32'(c1_err_cnt), 32'd0);
        check("unwritten_state", 32'(u1.state_q), 32'd0);
        cyc(1'b1, 1'b1, 5'd3, 8'h33, 1'b0, 8'd0, 1'b0);
        rd(5'd3);
        idle(1);
        check("lat1_not_early", 32'(c1_valid), 32'd0);
        idle(1);
        check("lat1_valid", 32'(c1_valid), 32'd1);
        check("lat1_ok", 32'(c1_ok), 32'd1);
        check("lat1_state_run", 32'(u1.state_q), 32'd1);
        idle(3);
        check("addr3_chk1", 32'(n_chk1 - b_chk1), 32'd1);
        check("addr3_chk3", 32'(n_chk3 - b_chk3), 32'd1);

        // Clean full round.
        do_reset();
        snap();
        write_all();
        for (int a = 0; a < 32; a++) rd(5'(a));
        idle(5);
        check("round_chk1", 32'(n_chk1 - b_chk1), 32'd32);
        check("round_bad1", 32'(n_bad1 - b_bad1), 32'd0);
        check("round_pass_cnt", 32'(n_rp1 - b_rp1), 32'd1);
        check("round_pass_at", 32'(rp_at1 - b_chk1), 32'd32);
        check("round_cnt1", 32'(c1_round_cnt), 32'd1);
        check("round_err_cnt1", 32'(c1_err_cnt), 32'd0);
        check("round_rd_err1", 32'(c1_err), 32'd0);
        check("round_state", 32'(u1.state_q), 32'd1);
        check("round_chk3", 32'(n_chk3 - b_chk3), 32'd32);
        check("round_cnt3", 32'(c3_round_cnt), 32'd1);

        // Corrupted read of addr 5 after clr; shadow survives clr.
        cyc(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        snap();
        for (int a = 0; a < 32; a++) begin
            if (a == 5) rdbad(5'd5, 8'hFF);
            else rd(5'(a));
        end
        idle(5);
        check("bad_chk1", 32'(n_chk1 - b_chk1), 32'd32);
        check("bad_bad1", 32'(n_bad1 - b_bad1), 32'd1);
        check("bad_at", 32'(bad_at1 - b_chk1), 32'd6);
        check("bad_no_round", 32'(n_rp1 - b_rp1), 32'd0);
        check("bad_err_cnt1", 32'(c1_err_cnt), 32'd1);
        check("bad_rd_err1", 32'(c1_err), 32'd1);
        check("bad_fe_addr", 32'(c1_fe_addr), 32'd5);
        check("bad_fe_exp", 32'(c1_fe_exp), 32'h05);
        check("bad_fe_act", 32'(c1_fe_act), 32'hFF);
        check("bad_err_cnt3", 32'(c3_err_cnt), 32'd1);
        check("bad_fe_addr3", 32'(c3_fe_addr), 32'd5);
        rdbad(5'd7, 8'h00);
        idle(5);
        check("second_err_cnt", 32'(c1_err_cnt), 32'd2);
        check("second_fe_addr", 32'(c1_fe_addr), 32'd5);
        check("second_fe_act", 32'(c1_fe_act), 32'hFF);

        // clr coinciding with a mismatch on addr 9.
        rdbad(5'd1, 8'h00);
        rdbad(5'd2, 8'h00);
        idle(5);
        check("pre_clr_err_cnt", 32'(c1_err_cnt), 32'd4);
        rdbad(5'd9, 8'h00);
        cyc(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        idle(1);
        check("clrcmp_err_cnt", 32'(c1_err_cnt), 32'd1);
        check("clrcmp_rd_err", 32'(c1_err), 32'd1);
        check("clrcmp_fe_addr", 32'(c1_fe_addr), 32'd9);
        check("clrcmp_fe_exp", 32'(c1_fe_exp), 32'h09);
        check("clrcmp_fe_act", 32'(c1_fe_act), 32'h00);
        check("clrcmp_round_cnt", 32'(c1_round_cnt), 32'd0);
        idle(3);
        check("clr3_err_cnt", 32'(c3_err_cnt), 32'd1);

        // 20 more mismatches saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) rdbad(5'(i), 8'hAA);
        idle(5);
        check("sat_err_cnt3", 32'(c3_err_cnt), 32'd15);
        check("sat_rd_err3", 32'(c3_err), 32'd1);
        check("nosat_err_cnt1", 32'(c1_err_cnt), 32'd21);
        rdbad(5'd4, 8'hAA);
        idle(5);
        check("sat_hold_err_cnt3", 32'(c3_err_cnt), 32'd15);

        // Reset with three reads in flight in the latency-3 checker.
        cyc(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        rd(5'd0);
        rd(5'd1);
        rd(5'd2);
        do_reset();
        snap();
        idle(6);
        check("rst_flight_chk3", 32'(n_chk3 - b_chk3), 32'd0);
        check("rst_flight_chk1", 32'(n_chk1 - b_chk1), 32'd0);
        check("rst_flight_err3", 32'(c3_err_cnt), 32'd0);
        write_all();
        for (int a = 0; a < 32; a++) rd(5'(a));
        idle(5);
        check("post_rst_chk3", 32'(n_chk3 - b_chk3), 32'd32);
        check("post_rst_bad3", 32'(n_bad3 - b_bad3), 32'd0);
        check("post_rst_round3", 32'(c3_round_cnt), 32'd1);
        check("post_rst_err3", 32'(c3_err_cnt), 32'd0);
        check("post_rst_rd_err3", 32'(c3_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
